answer_round: RTL and testbench

Round controller for the quiz responder, directly downstream of the settings stage. Consumes the configured answer time (BCD seconds), player count and add/subtract score amounts. Runs the countdown, locks the first valid buzz-in and applies the host's correct/wrong judgement to per-player BCD scores. Its outputs drive the display and the buzzer stages.

---
 rtl/answer_round_if.sv | 31 +++
 rtl/answer_round.sv | 174 +++++++++++++++++
 tb/tb_answer_round.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/answer_round_if.sv
// Quiz round controller bus: settings, host/player inputs and display/score outputs.
// master drives settings and pulses, slave (answer_round) returns round status.
interface answer_round_if;
  // Handshake: start, judge_ok and judge_bad are single-cycle pulses sampled on
  // the rising edge. There is no ready; pulses arriving in the wrong state are dropped.
  logic        endset;
  logic [7:0]  maxtime;
  logic [3:0]  maxuser;
  logic [3:0]  scorejia;
  logic [3:0]  scorejian;
  logic        start;
  logic [3:0]  buzz;
  logic        judge_ok;
  logic        judge_bad;
  logic [7:0]  remain;
  logic [3:0]  winner;
  logic        busy;
  logic        timeout;
  logic [31:0] score;
  logic [1:0]  state_dbg;

  modport master (
    output endset, maxtime, maxuser, scorejia, scorejian, start, buzz, judge_ok, judge_bad,
    input  remain, winner, busy, timeout, score, state_dbg
  );

  modport slave (
    input  endset, maxtime, maxuser, scorejia, scorejian, start, buzz, judge_ok, judge_bad,
    output remain, winner, busy, timeout, score, state_dbg
  );
endinterface

// File: rtl/answer_round.sv
// Quiz round controller: BCD countdown, first-buzz lock and BCD score judgement.
// Optional feature macro FOUL_PENALTY_EN: penalise buzzes made between rounds.
module answer_round #(
  parameter int TICK_DIV = 100_000_000
) (
  input logic          clk,
  input logic          rst,
  answer_round_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    buzz_q;
  logic [7:0]    remain;
  logic [3:0]    winner;
  logic          busy;
  logic          timeout;
  logic [31:0]   score;

  logic [3:0] user_mask;
  logic [3:0] edges;
  logic [3:0] first_edge;
  logic [3:0] jia;
  logic [3:0] jian;
  logic       tick;

  // Two-digit BCD plus one digit, clamped at 99.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] s, input logic [3:0] d);
    logic [4:0] lo;
    logic [4:0] hi;
    lo = {1'b0, s[3:0]} + {1'b0, d};
    hi = {1'b0, s[7:4]};
    if (lo > 5'd9) begin
      lo = lo - 5'd10;
      hi = hi + 5'd1;
    end
    if (hi > 5'd9) return 8'h99;
    return {hi[3:0], lo[3:0]};
  endfunction

  // Two-digit BCD minus one digit, clamped at 00.
  function automatic logic [7:0] bcd_sub_sat(input logic [7:0] s, input logic [3:0] d);
    logic [3:0] lo;
    logic [3:0] hi;
    hi = s[7:4];
    if (s[3:0] >= d) begin
      lo = s[3:0] - d;
    end else begin
      if (hi == 4'd0) return 8'h00;
      lo = s[3:0] + 4'd10 - d;
      hi = hi - 4'd1;
    end
    return {hi, lo};
  endfunction

  // Only called with a nonzero value.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    case (bus.maxuser)
      4'd0, 4'd1: user_mask = 4'b0001;
      4'd2:       user_mask = 4'b0011;
      4'd3:       user_mask = 4'b0111;
      default:    user_mask = 4'b1111;
    endcase
    jia        = (bus.scorejia  > 4'd9) ? 4'd9 : bus.scorejia;
    jian       = (bus.scorejian > 4'd9) ? 4'd9 : bus.scorejian;
    edges      = bus.buzz & ~buzz_q & user_mask;
    first_edge = edges & (~edges + 4'd1);
    tick       = (presc == PRE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      buzz_q  <= 4'd0;
      remain  <= 8'h00;
      winner  <= 4'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      score   <= 32'd0;
    end else begin
      buzz_q <= bus.buzz;
      case (state)
        IDLE: begin
          presc <= '0;
          if (bus.start && bus.endset) begin
            state   <= COUNT;
            busy    <= 1'b1;
            remain  <= bus.maxtime;
            winner  <= 4'd0;
            timeout <= 1'b0;
          end
`ifdef FOUL_PENALTY_EN
          if (bus.endset) begin
            for (int i = 0; i < 4; i++) begin
              if (edges[i]) score[8*i +: 8] <= bcd_sub_sat(score[8*i +: 8], jian);
            end
          end
`endif
        end
        COUNT: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (!bus.endset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            winner  <= 4'd0;
            timeout <= 1'b0;
          end else if (|edges) begin
            // A buzz beats a coincident tick, so remain freezes at its current value.
            state  <= LOCK;
            winner <= first_edge;
          end else if (remain == 8'h00) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (tick) begin
            remain <= bcd_dec(remain);
            if (remain == 8'h01) begin
              state   <= IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (!bus.endset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            winner  <= 4'd0;
            timeout <= 1'b0;
          end else if (bus.judge_ok && !bus.judge_bad) begin
            for (int i = 0; i < 4; i++) begin
              if (winner[i]) score[8*i +: 8] <= bcd_add_sat(score[8*i +: 8], jia);
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.judge_bad && !bus.judge_ok) begin
            for (int i = 0; i < 4; i++) begin
              if (winner[i]) score[8*i +: 8] <= bcd_sub_sat(score[8*i +: 8], jian);
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.remain    = remain;
  assign bus.winner    = winner;
  assign bus.busy      = busy;
  assign bus.timeout   = timeout;
  assign bus.score     = score;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_answer_round.sv
// Bench for answer_round: decimal-integer round model checked every cycle, plus
// directed scenarios with literal expectations. Honours FOUL_PENALTY_EN.
module tb_answer_round;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  answer_round_if bus();

  answer_round #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // Round model in plain decimal arithmetic.
  int        m_phase;   // 0 waiting, 1 counting down, 2 locked
  int        m_secs;
  int        m_cyc;
  int        m_win;     // -1 = none
  bit        m_to;
  int        m_score[4];
  logic [3:0] m_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [31:0] score_word();
    return {to_bcd(m_score[3]), to_bcd(m_score[2]), to_bcd(m_score[1]), to_bcd(m_score[0])};
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_secs  = 0;
    m_cyc   = 0;
    m_win   = -1;
    m_to    = 1'b0;
    m_prev  = 4'd0;
    for (int i = 0; i < 4; i++) m_score[i] = 0;
  endfunction

  function automatic void model_step();
    int users;
    int add;
    int sub;
    int first;
    logic [3:0] edges;
    bit tick;
    users = (bus.maxuser == 4'd0) ? 1 : (bus.maxuser > 4'd4) ? 4 : int'(bus.maxuser);
    add   = (bus.scorejia  > 4'd9) ? 9 : int'(bus.scorejia);
    sub   = (bus.scorejian > 4'd9) ? 9 : int'(bus.scorejian);
    for (int i = 0; i < 4; i++) edges[i] = (i < users) && bus.buzz[i] && !m_prev[i];
    m_prev = bus.buzz;
    first = -1;
    for (int i = 3; i >= 0; i--) if (edges[i]) first = i;
    case (m_phase)
      0: begin
        if (bus.start && bus.endset) begin
          m_phase = 1;
          m_secs  = from_bcd(bus.maxtime);
          m_win   = -1;
          m_to    = 1'b0;
          m_cyc   = 0;
        end
`ifdef FOUL_PENALTY_EN
        if (bus.endset)
          for (int i = 0; i < 4; i++)
            if (edges[i]) m_score[i] = (m_score[i] > sub) ? m_score[i] - sub : 0;
`endif
      end
      1: begin
        m_cyc++;
        tick = (m_cyc == TD);
        if (tick) m_cyc = 0;
        if (!bus.endset) begin
          m_phase = 0; m_win = -1; m_to = 1'b0;
        end else if (first >= 0) begin
          m_phase = 2; m_win = first;
        end else if (m_secs == 0) begin
          m_phase = 0; m_to = 1'b1;
        end else if (tick) begin
          m_secs--;
          if (m_secs == 0) begin
            m_phase = 0; m_to = 1'b1;
          end
        end
      end
      default: begin
        if (!bus.endset) begin
          m_phase = 0; m_win = -1; m_to = 1'b0;
        end else if (bus.judge_ok && !bus.judge_bad) begin
          m_score[m_win] = (m_score[m_win] + add > 99) ? 99 : m_score[m_win] + add;
          m_phase = 0;
        end else if (bus.judge_bad && !bus.judge_ok) begin
          m_score[m_win] = (m_score[m_win] > sub) ? m_score[m_win] - sub : 0;
          m_phase = 0;
        end
      end
    endcase
  endfunction

  task automatic compare_all();
    check("remain",  bus.remain,  to_bcd(m_secs));
    check("winner",  bus.winner,  (m_win < 0) ? 4'h0 : 4'(1 << m_win));
    check("busy",    bus.busy,    m_phase != 0);
    check("timeout", bus.timeout, m_to);
    check("score",   bus.score,   score_word());
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic round(input logic [3:0] b, input logic ok, input logic bad, output logic [3:0] w);
    bus.start = 1'b1; step(1); bus.start = 1'b0; step(1);
    bus.buzz = b; step(1); w = bus.winner; bus.buzz = 4'd0; step(1);
    bus.judge_ok = ok; bus.judge_bad = bad; step(1);
    bus.judge_ok = 1'b0; bus.judge_bad = 1'b0; step(1);
  endtask

  initial begin
    logic [3:0] w;
    logic [7:0] last;
    int n_chg;

    bus.endset = 1'b0; bus.maxtime = 8'h00; bus.maxuser = 4'd4;
    bus.scorejia = 4'd5; bus.scorejian = 4'd3; bus.start = 1'b0;
    bus.buzz = 4'd0; bus.judge_ok = 1'b0; bus.judge_bad = 1'b0;
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_remain", bus.remain, 8'h00);
    check("rst_winner", bus.winner, 4'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_timeout", bus.timeout, 1'b0);
    check("rst_score", bus.score, 32'h0);
    @(negedge clk) rst = 1'b0;
    bus.endset = 1'b1;
    step(2);

    // Countdown from 12 to timeout
    bus.maxtime = 8'h12;
    for (int v = 12; v >= 0; v--) exp_q.push_back(to_bcd(v));
    last = 8'hFF;
    n_chg = 0;
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.remain != last) begin
        last = bus.remain;
        n_chg++;
        if (exp_q.size() > 0) check("cd_seq", bus.remain, exp_q.pop_front());
      end
      if (!bus.busy) break;
      step(1);
    end
    check("cd_steps", n_chg, 13);
    check("cd_timeout", bus.timeout, 1'b1);
    check("cd_busy", bus.busy, 1'b0);
    check("cd_remain", bus.remain, 8'h00);
    check("cd_score", bus.score, 32'h0);
    exp_q.delete();

    // Simultaneous buzz, correct answers up to saturation
    for (int k = 1; k <= 20; k++) exp_q.push_back(to_bcd((5 * k > 99) ? 99 : 5 * k));
    for (int k = 0; k < 20; k++) begin
      round(4'b1010, 1'b1, 1'b0, w);
      if (k == 0) check("win_1010", w, 4'b0010);
      check("sat_seq", bus.score[15:8], exp_q.pop_front());
    end
    check("sat_final", bus.score[15:8], 8'h99);

    // Reset mid-round clears scores immediately
    bus.start = 1'b1; step(1); bus.start = 1'b0; step(2);
    rst = 1'b1;
    #1;
    check("mid_rst_score", bus.score, 32'h0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_remain", bus.remain, 8'h00);
    model_reset();
    #1 rst = 1'b0;
    step(1);

    // Disabled player, then wrong answers down to zero
    round(4'b0010, 1'b1, 1'b0, w);
    check("p1_five", bus.score[15:8], 8'h05);
    bus.maxuser = 4'd2;
    bus.start = 1'b1; step(1); bus.start = 1'b0; step(1);
    bus.buzz = 4'b1000; step(1);
    check("dis_busy", bus.busy, 1'b1);
    check("dis_winner", bus.winner, 4'h0);
    bus.buzz = 4'd0; step(1);
    bus.buzz = 4'b0010; step(1);
    check("en_winner", bus.winner, 4'b0010);
    bus.buzz = 4'd0;
    bus.judge_bad = 1'b1; step(1); bus.judge_bad = 1'b0;
    check("bad_02", bus.score[15:8], 8'h02);
    check("bad_busy", bus.busy, 1'b0);
    step(1);
    round(4'b0010, 1'b0, 1'b1, w);
    check("bad_floor", bus.score[15:8], 8'h00);

    // Buzz on the final tick, then abort from LOCK
    bus.maxuser = 4'd4;
    bus.maxtime = 8'h01;
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    step(3);
    bus.buzz = 4'b0001; step(1); bus.buzz = 4'd0;
    check("ft_busy", bus.busy, 1'b1);
    check("ft_remain", bus.remain, 8'h01);
    check("ft_timeout", bus.timeout, 1'b0);
    check("ft_winner", bus.winner, 4'b0001);
    bus.endset = 1'b0; step(1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_winner", bus.winner, 4'h0);
    check("abort_score", bus.score, 32'h0);
    bus.endset = 1'b1; step(1);

    // Conflicting judgement and start while busy
    bus.maxtime = 8'h12;
    bus.start = 1'b1; step(1); bus.start = 1'b0; step(1);
    bus.buzz = 4'b0100; step(1); bus.buzz = 4'd0;
    bus.judge_ok = 1'b1; bus.judge_bad = 1'b1; step(1);
    bus.judge_ok = 1'b0; bus.judge_bad = 1'b0;
    check("conflict_busy", bus.busy, 1'b1);
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    check("start_busy", bus.busy, 1'b1);
    check("start_remain", bus.remain, 8'h12);
    check("start_winner", bus.winner, 4'b0100);
    bus.judge_ok = 1'b1; step(1); bus.judge_ok = 1'b0;
    check("p2_ok", bus.score[23:16], 8'h05);
    check("p2_idle", bus.busy, 1'b0);
    step(1);

    // Buzz between rounds
    round(4'b0001, 1'b1, 1'b0, w);
    round(4'b0001, 1'b1, 1'b0, w);
    check("p0_ten", bus.score[7:0], 8'h10);
    bus.scorejian = 4'd4;
    bus.buzz = 4'b0001; step(1); bus.buzz = 4'd0; step(1);
`ifdef FOUL_PENALTY_EN
    check("foul", bus.score[7:0], 8'h06);
`else
    check("foul", bus.score[7:0], 8'h10);
`endif
    check("foul_busy", bus.busy, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 2500; i++) begin
      bus.endset    = ($urandom_range(0, 99) >= 3);
      bus.start     = ($urandom_range(0, 9) == 0);
      bus.judge_ok  = ($urandom_range(0, 11) == 0);
      bus.judge_bad = ($urandom_range(0, 11) == 0);
      bus.buzz      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      bus.maxuser   = 4'($urandom_range(0, 15));
      bus.scorejia  = 4'($urandom_range(0, 15));
      bus.scorejian = 4'($urandom_range(0, 15));
      bus.maxtime   = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
